// File: rtl/sdspi_arb_pkg.sv
// Shared types and widths for the sdspi host arbiter.
// Arbiter FSM states, plus the address and data widths of the sdspi host.
package sdspi_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        INIT_RST,
        INIT_WAIT,
        IDLE,
        OWN,
        ERR
    } arb_state_e;

endpackage

// File: rtl/sdspi_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requesting index strictly after
// last_idx wins. When nobody requests, valid is low and pick is all-zero.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand_idx = IDX_W'((int'(last_idx) + 1 + k) % N);
            if (!valid && req[cand_idx]) begin
                pick[cand_idx] = 1'b1;
                pick_idx       = cand_idx;
                valid          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdspi_arbiter.sv
// Shares one sdspihost between NUM_REQ requesters: runs the host reset/init
// sequence, grants round-robin ownership and muxes the owner onto the host.
module sdspi_arbiter
    import sdspi_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int RST_CYCLES   = 16,
    parameter int INIT_TIMEOUT = 2**24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reinit,
    output logic                      ready,
    output logic                      init_err,
    input  logic [NUM_REQ-1:0]        req,
    output logic [NUM_REQ-1:0]        grant,
    input  logic [NUM_REQ-1:0]        rq_r_block,
    input  logic [NUM_REQ-1:0]        rq_r_multi_block,
    input  logic [NUM_REQ-1:0]        rq_r_byte,
    input  logic [NUM_REQ-1:0]        rq_w_block,
    input  logic [NUM_REQ-1:0]        rq_w_byte,
    input  logic [NUM_REQ*ADDR_W-1:0] rq_block_addr,
    input  logic [NUM_REQ*DATA_W-1:0] rq_data_in,
    output logic [NUM_REQ-1:0]        rq_busy,
    output logic [NUM_REQ-1:0]        rq_err,
    output logic [DATA_W-1:0]         rq_data_out,
    output logic                      spi_rst,
    output logic                      spi_r_block,
    output logic                      spi_r_multi_block,
    output logic                      spi_r_byte,
    output logic                      spi_w_block,
    output logic                      spi_w_byte,
    output logic [ADDR_W-1:0]         spi_block_addr,
    output logic [DATA_W-1:0]         spi_data_in,
    input  logic                      spi_busy,
    input  logic                      spi_err,
    input  logic [DATA_W-1:0]         spi_data_out,
    output arb_state_e                dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(INIT_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(INIT_TIMEOUT - 1);

    // Handshake: a requester raises req and holds it for as long as it wants
    // the host; grant is registered, one-hot, and appears the cycle after IDLE
    // sees req. Ownership ends when the owner drops req and the host is not busy.
    arb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 own;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req      (req),
        .last_idx (owner_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT_RST;
            cnt_q   <= '0;
            grant_q <= '0;
            owner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        owner_d = owner_q;
        case (state_q)
            INIT_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = INIT_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INIT_WAIT: begin
                // A host error wins over a simultaneous busy drop.
                if (spi_err || (spi_busy && cnt_q == TMO_LAST)) begin
                    state_d = ERR;
                    cnt_d   = '0;
                end else if (!spi_busy) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (reinit) begin
                    state_d = INIT_RST;
                    cnt_d   = '0;
                end else if (pick_valid) begin
                    state_d = OWN;
                    grant_d = pick;
                    owner_d = pick_idx;
                end
            end
            OWN: begin
                if (!req[owner_q] && !spi_busy) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            ERR: begin
                if (reinit) begin
                    state_d = INIT_RST;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT_RST;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    assign own       = (state_q == OWN);
    assign ready     = own || (state_q == IDLE);
    assign init_err  = (state_q == ERR);
    assign spi_rst   = (state_q == INIT_RST);
    assign grant     = grant_q;
    assign dbg_state = state_q;
    assign rq_data_out = spi_data_out;

    // Only the registered owner reaches the host; everyone else sees busy.
    always_comb begin
        spi_r_block       = 1'b0;
        spi_r_multi_block = 1'b0;
        spi_r_byte        = 1'b0;
        spi_w_block       = 1'b0;
        spi_w_byte        = 1'b0;
        spi_block_addr    = '0;
        spi_data_in       = '0;
        rq_busy           = '1;
        rq_err            = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own && owner_q == IDX_W'(i)) begin
                spi_r_block       = rq_r_block[i];
                spi_r_multi_block = rq_r_multi_block[i];
                spi_r_byte        = rq_r_byte[i];
                spi_w_block       = rq_w_block[i];
                spi_w_byte        = rq_w_byte[i];
                spi_block_addr    = rq_block_addr[i*ADDR_W +: ADDR_W];
                spi_data_in       = rq_data_in[i*DATA_W +: DATA_W];
                rq_busy[i]        = spi_busy;
                rq_err[i]         = spi_err;
            end
        end
    end

endmodule

// File: tb/tb_sdspi_arbiter.sv
// Directed bench for sdspi_arbiter: expected grant changes and host commands
// are queued by the driver and checked by an independent monitor.
module tb_sdspi_arbiter;
    import sdspi_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reinit;
    logic        ready, init_err;
    logic [1:0]  req, grant;
    logic [1:0]  rq_r_block, rq_r_multi_block, rq_r_byte, rq_w_block, rq_w_byte;
    logic [63:0] rq_block_addr;
    logic [15:0] rq_data_in;
    logic [1:0]  rq_busy, rq_err;
    logic [7:0]  rq_data_out;
    logic        spi_rst, spi_r_block, spi_r_multi_block, spi_r_byte, spi_w_block, spi_w_byte;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_in;
    logic        spi_busy, spi_err;
    logic [7:0]  spi_data_out;
    arb_state_e  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  exp_grant_q[$];
    logic [44:0] exp_cmd_q[$];

    always #5 clk = ~clk;

    sdspi_arbiter #(
        .NUM_REQ      (2),
        .RST_CYCLES   (16),
        .INIT_TIMEOUT (100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .reinit            (reinit),
        .ready             (ready),
        .init_err          (init_err),
        .req               (req),
        .grant             (grant),
        .rq_r_block        (rq_r_block),
        .rq_r_multi_block  (rq_r_multi_block),
        .rq_r_byte         (rq_r_byte),
        .rq_w_block        (rq_w_block),
        .rq_w_byte         (rq_w_byte),
        .rq_block_addr     (rq_block_addr),
        .rq_data_in        (rq_data_in),
        .rq_busy           (rq_busy),
        .rq_err            (rq_err),
        .rq_data_out       (rq_data_out),
        .spi_rst           (spi_rst),
        .spi_r_block       (spi_r_block),
        .spi_r_multi_block (spi_r_multi_block),
        .spi_r_byte        (spi_r_byte),
        .spi_w_block       (spi_w_block),
        .spi_w_byte        (spi_w_byte),
        .spi_block_addr    (spi_block_addr),
        .spi_data_in       (spi_data_in),
        .spi_busy          (spi_busy),
        .spi_err           (spi_err),
        .spi_data_out      (spi_data_out),
        .dbg_state         (dbg_state)
    );

    function automatic logic [44:0] cmd_word();
        return {spi_r_block, spi_r_multi_block, spi_r_byte, spi_w_block, spi_w_byte,
                spi_block_addr, spi_data_in};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant change and every host strobe pops one expectation.
    initial begin
        logic [1:0]  prev_grant;
        logic [1:0]  eg;
        logic [44:0] ec;
        prev_grant = 2'b00;
        forever begin
            @(negedge clk);
            if (grant !== prev_grant) begin
                checks++;
                if (exp_grant_q.size() == 0) begin
                    failures++;
                    $display("FAIL grant_seq: got %b expected no change", grant);
                end else begin
                    eg = exp_grant_q.pop_front();
                    if (grant !== eg) begin
                        failures++;
                        $display("FAIL grant_seq: got %b expected %b", grant, eg);
                    end
                end
                prev_grant = grant;
            end
            if (cmd_word()[44:40] != 5'b0) begin
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    failures++;
                    $display("FAIL host_cmd: got %h expected none", cmd_word());
                end else begin
                    ec = exp_cmd_q.pop_front();
                    if (cmd_word() !== ec) begin
                        failures++;
                        $display("FAIL host_cmd: got %h expected %h", cmd_word(), ec);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        reinit = 1'b0;
        req = '0;
        rq_r_block = '0; rq_r_multi_block = '0; rq_r_byte = '0; rq_w_block = '0; rq_w_byte = '0;
        rq_block_addr = '0;
        rq_data_in = '0;
        spi_busy = 1'b1;
        spi_err = 1'b0;
        spi_data_out = 8'hA5;
        #2 rst = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_init_err", init_err, 1'b0);
        chk("rst_spi_rst", spi_rst, 1'b1);
        chk("rst_host_cmd", cmd_word(), 45'd0);
        chk("rst_state", dbg_state, INIT_RST);

        // Init: spi_rst high for 16 cycles, busy falls 40 cycles later.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (!spi_rst) break;
        end
        chk("rst_cycles", n, 16);
        chk("init_wait_state", dbg_state, INIT_WAIT);
        repeat (40) tick();
        chk("ready_before_busy_fall", ready, 1'b0);
        spi_busy = 1'b0;
        tick();
        chk("ready_after_busy_fall", ready, 1'b1);
        chk("idle_state", dbg_state, IDLE);

        // Round robin with both requesting.
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b00);
        exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b00);
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b00);
        req = 2'b11;
        tick();
        chk("rr_first", grant, 2'b01);
        chk("rr_busy_loser", rq_busy, 2'b10);
        chk("data_out", rq_data_out, 8'hA5);
        req = 2'b10;
        tick();
        chk("rr_release_gap", grant, 2'b00);
        tick();
        chk("rr_second", grant, 2'b10);
        req = 2'b01;
        tick();
        chk("rr_release_gap2", grant, 2'b00);
        tick();
        chk("rr_alternate", grant, 2'b01);
        req = 2'b00;
        tick();
        chk("rr_drop", grant, 2'b00);

        // Owner 0 writes a block and drains; requester 1 strobes are ignored.
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b00);
        exp_cmd_q.push_back({5'b00010, 32'h0000_0123, 8'h5A});
        req = 2'b01;
        tick();
        chk("own0_grant", grant, 2'b01);
        rq_block_addr = {32'hDEAD_BEEF, 32'h0000_0123};
        rq_data_in = {8'hC3, 8'h5A};
        rq_w_block = 2'b01;
        rq_r_byte = 2'b10;
        rq_r_block = 2'b10;
        tick();
        rq_w_block = 2'b00;
        spi_busy = 1'b1;
        req = 2'b00;
        repeat (3) tick();
        chk("drain_hold", grant, 2'b01);
        chk("drain_addr", spi_block_addr, 32'h0000_0123);
        chk("drain_busy", rq_busy, 2'b11);
        spi_busy = 1'b0;
        rq_r_byte = 2'b00;
        rq_r_block = 2'b00;
        tick();
        chk("drain_release", grant, 2'b00);

        // Host error while requester 1 owns.
        exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b00);
        req = 2'b10;
        tick();
        chk("own1_grant", grant, 2'b10);
        spi_err = 1'b1;
        tick();
        chk("err_route", rq_err, 2'b10);
        chk("err_grant_kept", grant, 2'b10);
        chk("err_state_own", dbg_state, OWN);
        spi_err = 1'b0;
        req = 2'b00;
        tick();
        chk("err_release", grant, 2'b00);

        // Reinit with busy stuck high: timeout after 100 cycles.
        spi_busy = 1'b1;
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        chk("reinit_spi_rst", spi_rst, 1'b1);
        chk("reinit_ready", ready, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (!spi_rst) break;
            tick();
        end
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (init_err) break;
        end
        chk("timeout_cycles", n, 100);
        chk("timeout_ready", ready, 1'b0);
        chk("timeout_spi_rst", spi_rst, 1'b0);
        spi_busy = 1'b0;
        tick();
        chk("init_err_sticky", init_err, 1'b1);
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        chk("reinit_clears_err", init_err, 1'b0);
        chk("reinit_from_err", spi_rst, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            tick();
        end
        chk("reinit_ready_again", ready, 1'b1);

        // Asynchronous reset while requester 0 owns.
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b00);
        req = 2'b01;
        tick();
        chk("own0_again", grant, 2'b01);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_grant", grant, 2'b00);
        chk("async_spi_rst", spi_rst, 1'b1);
        chk("async_ready", ready, 1'b0);
        req = 2'b00;
        spi_busy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (!spi_rst) break;
        end
        chk("rerun_rst_cycles", n, 16);
        spi_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            tick();
        end
        chk("rerun_ready", ready, 1'b1);

        repeat (3) tick();
        chk("grant_queue_empty", exp_grant_q.size(), 0);
        chk("cmd_queue_empty", exp_cmd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
